// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. The external pc register is loaded from nextPC on
// every rising edge and fed back on addr. The unit issues one instruction
// memory request per cycle when its output register can take the word. It
// captures the returned word together with its address, and presents it
// downstream through a valid/ready output register.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : asynchronous, active-low reset
//   addr            : current PC from the pc register
//   nextPC          : value the pc register loads on the next rising edge
//   imem_req        : instruction memory request valid
//   imem_addr       : request address (always addr)
//   imem_ready      : memory accepts the request; imem_rdata valid same cycle
//   imem_rdata      : instruction word
//   redirect        : taken branch/jump; flushes and reloads the PC
//   redirect_target : new PC (low two bits dropped)
//   instr_valid     : output register holds an instruction
//   instr_ready     : downstream accepts instr this cycle
//   instr           : fetched instruction word
//   instr_pc        : address instr was fetched from
//   fetch_count     : number of accepted output handshakes (wraps)
//
// The FSM state is held in the internal signal "state" (state_t) for
// hierarchical observation.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   output logic [31:0] nextPC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Handshake rules, both interfaces:
   //   memory side : a transfer happens when imem_req && imem_ready; the
   //                 word on imem_rdata is taken in that same cycle.
   //   output side : a transfer happens when instr_valid && instr_ready;
   //                 while instr_valid && !instr_ready, instr, instr_pc and
   //                 instr_valid do not change (a redirect flush excepted).
   logic free;     // output register can take a new word this cycle
   logic accept;   // downstream takes the current word this cycle
   logic capture;  // memory word is written into the output register
   logic flush;    // redirect empties the output register

   assign free      = !instr_valid || instr_ready;
   assign accept    = instr_valid && instr_ready;
   assign imem_addr = addr;

   always_comb begin
      state_nxt = state;
      nextPC    = addr;
      imem_req  = 1'b0;
      capture   = 1'b0;
      flush     = 1'b0;
      case (state)
         BOOT: begin
            // Redirect is ignored here; the first request goes to the vector.
            nextPC    = RESET_VECTOR;
            state_nxt = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               nextPC = {redirect_target[31:2], 2'b00};
               flush  = 1'b1;
            end else if (!free) begin
               state_nxt = HOLD;
            end else begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  capture = 1'b1;
                  nextPC  = addr + 32'd4;  // wraps naturally at 2^32
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               nextPC    = {redirect_target[31:2], 2'b00};
               flush     = 1'b1;
               state_nxt = FETCH;
            end else if (instr_ready) begin
               state_nxt = FETCH;
            end
         end
         default: begin
            nextPC    = RESET_VECTOR;
            state_nxt = BOOT;
         end
      endcase
      // Keep the pc register pointed at the vector for the whole reset.
      if (!reset) begin
         nextPC   = RESET_VECTOR;
         imem_req = 1'b0;
         capture  = 1'b0;
         flush    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Output register. A flush wins over everything; a capture in the same
   // cycle as an accept simply replaces the word and keeps valid high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_valid <= 1'b0;
         instr       <= 32'h0;
         instr_pc    <= 32'h0;
      end else if (flush) begin
         instr_valid <= 1'b0;
      end else if (capture) begin
         instr_valid <= 1'b1;
         instr       <= imem_rdata;
         instr_pc    <= addr;
      end else if (accept) begin
         instr_valid <= 1'b0;
      end
   end

   // Counts every accepted word, including one accepted alongside a redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count <= 32'h0;
      end else if (accept) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit with a pc register closed around nextPC/addr. A reference
// model tracks what the unit must present each cycle, and a compare process
// checks every output at each falling edge. Directed sequences pin the model
// with literal expectations; a randomized phase then exercises memory stalls,
// downstream backpressure, redirects and mid-cycle resets.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] PAT = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] nextPC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] fetch_count;

   logic        use_pattern;
   logic [31:0] rand_rdata;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clk             (clk),
      .reset           (reset),
      .addr            (addr),
      .nextPC          (nextPC),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .fetch_count     (fetch_count)
   );

   // ---------------- clock / reset / pc register ----------------
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) addr <= RV;
      else        addr <= nextPC;
   end

   assign imem_rdata = use_pattern ? (addr ^ PAT) : rand_rdata;

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; directed checks happen
   // 2 units after it, the model compare at the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ready      = 1'b1;
      instr_ready     = 1'b1;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      use_pattern     = 1'b1;
      rand_rdata      = 32'h0;
   endtask

   // Holds reset low for 5 cycles, releases it, and returns inside the
   // BOOT cycle with outputs settled.
   task automatic do_reset();
      reset = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      #1;
   endtask

   // ---------------- reference model + compare ----------------
   // Model of the registered view: whether this is the first cycle after
   // reset, whether the output register holds a word, that word and its
   // address, the count of accepted words, and whether the word was refused
   // downstream last cycle (a refused word costs one idle cycle before the
   // memory is asked again).
   logic        m_boot;
   logic        m_valid;
   logic        m_refused;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_count;

   always @(negedge clk) begin : compare
      logic        e_req;
      logic [31:0] e_next;
      logic        acc;
      logic        take;
      if (!reset) begin
         m_boot    = 1'b1;
         m_valid   = 1'b0;
         m_refused = 1'b0;
         m_instr   = 32'h0;
         m_pc      = 32'h0;
         m_count   = 32'h0;
      end
      if (!reset || m_boot) begin
         e_req  = 1'b0;
         e_next = RV;
      end else if (redirect) begin
         e_req  = 1'b0;
         e_next = {redirect_target[31:2], 2'b00};
      end else if (m_refused || (m_valid && !instr_ready)) begin
         e_req  = 1'b0;
         e_next = addr;
      end else begin
         e_req  = 1'b1;
         e_next = imem_ready ? addr + 32'd4 : addr;
      end
      chk1("imem_req", imem_req, e_req);
      chk("nextPC", nextPC, e_next);
      chk("imem_addr", imem_addr, addr);
      chk1("instr_valid", instr_valid, m_valid);
      chk("fetch_count", fetch_count, m_count);
      if (!reset || m_valid) begin
         chk("instr", instr, m_instr);
         chk("instr_pc", instr_pc, m_pc);
      end
      if (reset) begin
         acc  = m_valid && instr_ready;
         take = e_req && imem_ready;
         if (m_boot) begin
            m_boot = 1'b0;
         end else begin
            if (acc) m_count = m_count + 32'd1;
            m_refused = !redirect && m_valid && !instr_ready;
            if (redirect) begin
               m_valid = 1'b0;
            end else if (take) begin
               m_valid = 1'b1;
               m_instr = imem_rdata;
               m_pc    = addr;
            end else if (acc) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      #2;

      // Reset, boot cycle and straight-line fetch.
      do_reset();
      chk("boot_nextPC", nextPC, RV);
      chk1("boot_req", imem_req, 1'b0);
      step(); #1;
      chk1("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, RV);
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         chk1("seq_valid", instr_valid, 1'b1);
         chk("seq_pc", instr_pc, 32'(4 * i));
      end
      step(); #1;
      chk("seq_count", fetch_count, 32'd4);

      // Downstream backpressure after the word at 0x4.
      idle_inputs();
      do_reset();
      step(); step(); step();
      instr_ready = 1'b0;
      #1;
      chk("bp_instr", instr, 32'hA5A5_0004);
      chk1("bp_req", imem_req, 1'b0);
      chk("bp_addr", addr, 32'h8);
      repeat (3) begin
         step(); #1;
         chk("bp_hold_instr", instr, 32'hA5A5_0004);
         chk1("bp_hold_valid", instr_valid, 1'b1);
         chk1("bp_hold_req", imem_req, 1'b0);
         chk("bp_hold_addr", addr, 32'h8);
      end
      instr_ready = 1'b1;
      step(); #1;
      chk1("bp_resume_req", imem_req, 1'b1);
      chk("bp_resume_addr", imem_addr, 32'h8);
      step(); #1;
      chk("bp_resume_pc", instr_pc, 32'h8);

      // Redirect while a word is valid (and accepted in the same cycle).
      idle_inputs();
      do_reset();
      step(); step();
      redirect        = 1'b1;
      redirect_target = 32'h43;
      #1;
      chk("rd_nextPC", nextPC, 32'h40);
      chk1("rd_req", imem_req, 1'b0);
      step();
      redirect = 1'b0;
      #1;
      chk1("rd_flush", instr_valid, 1'b0);
      chk("rd_addr", addr, 32'h40);
      chk("rd_count", fetch_count, 32'd1);
      step(); #1;
      chk("rd_pc", instr_pc, 32'h40);
      chk("rd_addr_next", addr, 32'h44);

      // Memory wait of three cycles at 0x10.
      idle_inputs();
      do_reset();
      step();
      imem_ready      = 1'b0;
      redirect        = 1'b1;
      redirect_target = 32'h10;
      step();
      redirect = 1'b0;
      #1;
      chk("mw_addr", addr, 32'h10);
      chk1("mw_req", imem_req, 1'b1);
      chk1("mw_valid", instr_valid, 1'b0);
      repeat (2) begin
         step(); #1;
         chk("mw_addr", addr, 32'h10);
         chk1("mw_req", imem_req, 1'b1);
         chk1("mw_valid", instr_valid, 1'b0);
      end
      step();
      imem_ready = 1'b1;
      #1;
      chk("mw_ready_addr", imem_addr, 32'h10);
      step(); #1;
      chk1("mw_got_valid", instr_valid, 1'b1);
      chk("mw_got_pc", instr_pc, 32'h10);
      chk("mw_got_instr", instr, 32'hA5A5_0010);

      // Address wrap, then reset asserted mid-HOLD between edges.
      idle_inputs();
      do_reset();
      step();
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      #1;
      chk("wrap_addr", addr, 32'hFFFF_FFFC);
      chk("wrap_nextPC", nextPC, 32'h0);
      chk1("wrap_req", imem_req, 1'b1);
      step(); #1;
      chk("wrap_addr0", addr, 32'h0);
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      step();
      instr_ready = 1'b0;
      #1;
      chk("wrap_count", fetch_count, 32'd1);
      step(); #1;
      chk1("hold_req", imem_req, 1'b0);
      chk1("hold_valid", instr_valid, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      chk1("ar_valid", instr_valid, 1'b0);
      chk("ar_count", fetch_count, 32'd0);
      chk("ar_instr", instr, 32'd0);
      chk("ar_pc", instr_pc, 32'd0);
      chk1("ar_req", imem_req, 1'b0);
      chk("ar_nextPC", nextPC, RV);

      // Randomized traffic with changing stall/backpressure rates.
      idle_inputs();
      use_pattern = 1'b0;
      do_reset();
      begin
         int p_mem;
         int p_out;
         p_mem = 3;
         p_out = 3;
         for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
               p_mem = $urandom_range(0, 4);
               p_out = $urandom_range(0, 4);
            end
            step();
            imem_ready      = ($urandom_range(0, 4) >= p_mem);
            instr_ready     = ($urandom_range(0, 4) >= p_out);
            redirect        = ($urandom_range(0, 15) == 0);
            redirect_target = $urandom;
            rand_rdata      = $urandom;
            if (i % 700 == 699) begin
               #2;
               reset = 1'b0;
               repeat (2) step();
               reset = 1'b1;
            end
         end
      end
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
